led_shift_ctrl: RTL
===================

# led_shift_ctrl

Sequencing controller for the LED shifter. It owns the phase timer's `clear`/`enable` inputs and decodes the timer's one-hot phase outputs (`trigger1..3`) into shift ticks. It shifts an LED pattern register in rotate or ping-pong mode, with start/pause/stop control and an optional step count. It sits between the board's button/switch synchronisers and the timer, and drives the LED pins directly.

## Interface
- `WIDTH`, 8: LED register width, ≥2.
- `STEPW`, 8: width of the step-count input.
- `clk` in 1: system clock, rising edge.
- `async_nreset` in 1: asynchronous active-low reset.
- `start` in 1: level, sampled each cycle. Honoured only in IDLE.
- `pause` in 1: single-cycle pulse. Toggles RUN/PAUSE.
- `stop` in 1: level or pulse. Abort to IDLE.
- `seed` in WIDTH: pattern loaded on start.
- `dir` in 1: initial direction, loaded on start. 0 = left (toward MSB), 1 = right.
- `mode` in 1: loaded on start. 0 = rotate, 1 = ping-pong.
- `speed` in 1: live. 1 = tick on every phase change, 0 = tick on `trigger1` rising only.
- `steps` in STEPW: shift count, loaded on start. 0 = run forever.
- `trigger1`, `trigger2`, `trigger3` in 1 each: phase timer outputs (one-hot).
- `timer_clear` out 1: to timer `clear`.
- `timer_enable` out 1: to timer `enable`.
- `leds` out WIDTH: pattern register.
- `busy` out 1: high in ARM, RUN, PAUSE.
- `done` out 1: one-cycle pulse when the step count expires.

## Operation
- **States:** IDLE, ARM, RUN, PAUSE.
- **Outputs by state:**
  - IDLE: `timer_clear`=1, `timer_enable`=0.
  - ARM: `timer_clear`=1, `timer_enable`=0.
  - RUN: `timer_clear`=0, `timer_enable`=1.
  - PAUSE: `timer_clear`=0, `timer_enable`=0. Timer holds its count.
- **Transition priority:** stop > pause > start/tick.
  - IDLE, `start`=1 & `stop`=0 → ARM. Load `leds`←`seed`, `dir_q`←`dir`, `mode_q`←`mode`, `remaining`←`steps`.
  - ARM → RUN unconditionally, after one cycle. Also set `phase_q`←3'b001.
  - RUN, `pause` → PAUSE. PAUSE, `pause` → RUN.
  - Any state, `stop` → IDLE. `leds` hold their value; no `done` pulse.
- **Phase sampling:** `phase`={`trigger3`,`trigger2`,`trigger1`}. `phase_q` is registered every cycle in RUN and PAUSE.
- **Tick** (RUN only, combinational):
  - `speed`=1: `phase`≠`phase_q`.
  - `speed`=0: `trigger1` & ~`phase_q[0]`.
  - Non-one-hot phase values are not filtered.
- **Shift on tick:**
  - Rotate: left = {`leds[WIDTH-2:0]`,`leds[WIDTH-1]`}; right = mirror.
  - Ping-pong: if `dir_q`=0 and `leds[WIDTH-1]`=1, flip `dir_q` to 1 and shift right this tick. Symmetrically, if `dir_q`=1 and `leds[0]`=1, flip to 0 and shift left. Vacated bit fills with 0.
  - `seed`=0 shifts zeros; this is legal.
- **Step count:**
  - With `remaining`≠0, each shift decrements it.
  - A shift taken with `remaining`=1 pulses `done` and moves to IDLE in the same clock edge; `leds` show the final pattern.
  - With `steps`=0 the count never expires.
- **Pause/tick collision:** `pause` and tick in the same RUN cycle: pause wins, no shift. `phase_q` still updates.

## Timing
- **Reset values:** state IDLE, `leds`=0, `dir_q`=0, `mode_q`=0, `remaining`=0, `phase_q`=3'b001, `done`=0, `busy`=0, `timer_clear`=1, `timer_enable`=0.
- **Start latency:** `start` sampled at edge S. ARM runs during S+1; RUN begins at cycle R=S+2.
- **Timer cadence:** the timer spends 4 enabled cycles per phase. The first phase change is visible at R+4.
- **speed=1:** shift edges register at R+4, R+8, R+12, …; new `leds` are visible one cycle after each phase change (R+5, R+9, R+13, …).
- **speed=0:** `trigger1` rises at R+12, so the first new `leds` are visible at R+13, then every 12 RUN cycles.
- **Pause cycles:** PAUSE cycles extend the schedule 1:1. The tick phase alignment is preserved.
- **`done`:** asserted in the same cycle the final `leds` value is visible; `busy` is low from that cycle.
- **Reset mid-run:** immediate return to reset values.

## Test plan
- WIDTH=8, seed=8'h01, dir=0, mode=0, speed=1, steps=3, start → `leds` 02@R+5, 04@R+9, 08@R+13; `done` high for exactly R+13; IDLE; `timer_clear`=1.
- seed=8'h80, dir=0, mode=0, speed=0, steps=0 → `leds` 01@R+13, 02@R+25; continues until `stop`. `stop` → IDLE, `leds` held at the last value, `done`=0.
- mode=1, seed=8'h40, dir=0, speed=1, steps=4 → sequence 80, 40, 20, 10; `dir_q` flips at the second shift.
- speed=1: pause at R+2, hold for 10 cycles, pause again → first shift visible at R+15, not R+5; `timer_enable`=0 throughout the pause.
- Simultaneous `pause` and tick, and simultaneous `stop` and tick → no shift in either case; `stop` also clears `busy` the next cycle.
- Deassert `async_nreset` mid-RUN → all outputs return to reset values asynchronously; `start` afterwards behaves as in the first scenario.

Source files
------------

// File: rtl/led_shift_ctrl.sv
// -----------------------------------------------------------------------------
// led_shift_ctrl
//
// Sequencing controller for the LED shifter. It drives the phase timer's
// clear/enable, turns the timer's one-hot phase outputs into shift ticks and
// shifts an LED pattern register in rotate or ping-pong mode. It supports
// start/pause/stop control and an optional step count.
//
// State table
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | waiting for start; timer held clear; leds hold last pattern
//   S_ARM   | one cycle after start; timer still clear, phase tracker reset
//   S_RUN   | timer running; ticks shift the pattern
//   S_PAUSE | timer frozen (not cleared); resumes on the next pause pulse
//
// Ports
//   clk           system clock, rising edge
//   async_nreset  asynchronous active-low reset
//   start         level; honoured only in IDLE (ignored while stop is high)
//   pause         single-cycle pulse; toggles RUN/PAUSE
//   stop          level or pulse; abort to IDLE from any state
//   seed          pattern loaded on start
//   dir           initial direction on start (0 = toward MSB, 1 = toward LSB)
//   mode          loaded on start (0 = rotate, 1 = ping-pong)
//   speed         live; 1 = tick on every phase change, 0 = trigger1 rise only
//   steps         shift count loaded on start; 0 = run forever
//   trigger1..3   one-hot phase outputs of the timer
//   timer_clear   to timer clear
//   timer_enable  to timer enable
//   leds          pattern register
//   busy          high in ARM, RUN and PAUSE
//   done          one-cycle pulse when the step count expires
// -----------------------------------------------------------------------------
module led_shift_ctrl #(
  parameter int WIDTH = 8,
  parameter int STEPW = 8
) (
  input  logic             clk,
  input  logic             async_nreset,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic [WIDTH-1:0] seed,
  input  logic             dir,
  input  logic             mode,
  input  logic             speed,
  input  logic [STEPW-1:0] steps,
  input  logic             trigger1,
  input  logic             trigger2,
  input  logic             trigger3,
  output logic             timer_clear,
  output logic             timer_enable,
  output logic [WIDTH-1:0] leds,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_RUN   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] leds_q, leds_d;
  logic             dir_q, dir_d;
  logic             mode_q, mode_d;
  logic [STEPW-1:0] remaining_q, remaining_d;
  logic [2:0]       phase_q, phase_d;
  logic             done_q, done_d;

  logic [2:0]       phase;
  logic             tick;
  logic [WIDTH-1:0] shifted;
  logic             dir_next;

  assign phase = {trigger3, trigger2, trigger1};

  // Tick only exists in RUN. In PAUSE phase_q still follows the timer, so a
  // phase change that lands while paused is absorbed and never becomes a tick.
  always_comb begin
    tick = 1'b0;
    if (state_q == S_RUN) begin
      if (speed) begin
        tick = (phase != phase_q);
      end else begin
        tick = trigger1 & ~phase_q[0];
      end
    end
  end

  // Next pattern and direction for a shift taken this cycle.
  always_comb begin
    shifted  = leds_q;
    dir_next = dir_q;
    if (!mode_q) begin
      if (!dir_q) begin
        shifted = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
      end else begin
        shifted = {leds_q[0], leds_q[WIDTH-1:1]};
      end
    end else begin
      // Ping-pong: reverse when the lit bit already sits at the edge we are
      // heading toward, and shift the other way in the same tick.
      if (!dir_q && leds_q[WIDTH-1]) begin
        dir_next = 1'b1;
      end else if (dir_q && leds_q[0]) begin
        dir_next = 1'b0;
      end
      if (dir_next) begin
        shifted = {1'b0, leds_q[WIDTH-1:1]};
      end else begin
        shifted = {leds_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    leds_d      = leds_q;
    dir_d       = dir_q;
    mode_d      = mode_q;
    remaining_d = remaining_q;
    phase_d     = phase_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d     = S_ARM;
          leds_d      = seed;
          dir_d       = dir;
          mode_d      = mode;
          remaining_d = steps;
        end
      end

      S_ARM: begin
        phase_d = 3'b001;
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        phase_d = phase;
        if (stop) begin
          state_d = S_IDLE;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else if (tick) begin
          leds_d = shifted;
          dir_d  = dir_next;
          if (remaining_q != '0) begin
            remaining_d = remaining_q - STEPW'(1);
            if (remaining_q == STEPW'(1)) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end

      S_PAUSE: begin
        phase_d = phase;
        if (stop) begin
          state_d = S_IDLE;
        end else if (pause) begin
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state_q     <= S_IDLE;
      leds_q      <= '0;
      dir_q       <= 1'b0;
      mode_q      <= 1'b0;
      remaining_q <= '0;
      phase_q     <= 3'b001;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      leds_q      <= leds_d;
      dir_q       <= dir_d;
      mode_q      <= mode_d;
      remaining_q <= remaining_d;
      phase_q     <= phase_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    timer_clear  = 1'b0;
    timer_enable = 1'b0;
    case (state_q)
      S_IDLE, S_ARM: timer_clear  = 1'b1;
      S_RUN:         timer_enable = 1'b1;
      default: begin
        timer_clear  = 1'b0;
        timer_enable = 1'b0;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign leds = leds_q;
  assign done = done_q;

endmodule
